// File: rtl/traffic_light_sequencer_if.sv
// Bundle of the demand/hold inputs and the phase outputs of the traffic light sequencer.
// The controller-side master drives hold/car_present; the sequencer (slave) drives the phase outputs.
interface traffic_light_sequencer_if;
    logic       hold;
    logic [3:0] car_present;
    logic [2:0] Q;
    logic [7:0] sec_left;
    logic       tick;

    modport master (output hold, car_present, input  Q, sec_left, tick);
    modport slave  (input  hold, car_present, output Q, sec_left, tick);
endinterface

// File: rtl/traffic_light_sequencer.sv
// Four-way traffic light phase controller: prescaled tick, per-phase countdown and a
// demand-driven choice of the next direction at each yellow expiry.
module traffic_light_sequencer #(
    parameter int TICK_DIV   = 100_000_000,
    parameter int GREEN_SEC  = 10,
    parameter int YELLOW_SEC = 3
) (
    input  logic                       clk,
    input  logic                       reset_n,
    traffic_light_sequencer_if.slave   bus
);
    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic [2:0]    q_q, q_d;
    logic [7:0]    sec_q, sec_d;
    logic          tick_evt;
    logic [1:0]    dir_q;
    logic [3:0]    rot;
    logic [1:0]    ofs;
    logic [1:0]    next_dir;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            q_q     <= 3'b000;
            sec_q   <= 8'(GREEN_SEC);
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            q_q     <= q_d;
            sec_q   <= sec_d;
        end
    end

    // The phase advances on the same edge that raises tick, so both share tick_evt.
    assign tick_evt = !bus.hold && (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (!bus.hold) begin
            if (tick_evt) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // rot[k] is the demand of the direction k+1 steps ahead (k=3 is the current one).
    assign dir_q = q_q[2:1];
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            assign rot[gi] = bus.car_present[dir_q + 2'(gi + 1)];
        end
    endgenerate

    always_comb begin
        ofs = 2'd1;
        if      (rot[0]) ofs = 2'd1;
        else if (rot[1]) ofs = 2'd2;
        else if (rot[2]) ofs = 2'd3;
        else if (rot[3]) ofs = 2'd0;
        next_dir = dir_q + ofs;
    end

    // Next-state logic
    always_comb begin
        q_d   = q_q;
        sec_d = sec_q;
        if (tick_evt) begin
            if (sec_q > 8'd1) begin
                sec_d = sec_q - 8'd1;
            end else if (!q_q[0]) begin
                q_d   = {q_q[2:1], 1'b1};
                sec_d = 8'(YELLOW_SEC);
            end else begin
                q_d   = {next_dir, 1'b0};
                sec_d = 8'(GREEN_SEC);
            end
        end
    end

    // Output logic
    always_comb begin
        bus.Q        = q_q;
        bus.sec_left = sec_q;
        bus.tick     = tick_q;
    end
endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Directed bench for traffic_light_sequencer with TICK_DIV=4, GREEN_SEC=3, YELLOW_SEC=2.
module tb_traffic_light_sequencer;
    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    traffic_light_sequencer_if bus ();

    traffic_light_sequencer #(
        .TICK_DIV  (4),
        .GREEN_SEC (3),
        .YELLOW_SEC(2)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_phase(input string tag, input int q, input int s);
        check({tag, ".Q"}, 32'(bus.Q), 32'(q));
        check({tag, ".sec"}, 32'(bus.sec_left), 32'(s));
    endtask

    int exp_q [7] = '{2, 3, 4, 5, 6, 7, 0};

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0;
        bus.hold = 1'b0;
        bus.car_present = 4'b0000;

        // 1: reset and first tick
        step(5);
        chk_phase("rst", 0, 3);
        check("rst.tick", 32'(bus.tick), 0);
        reset_n = 1'b1;
        step(3);
        check("pre_tick", 32'(bus.tick), 0);
        step(1);
        check("first_tick", 32'(bus.tick), 1);
        chk_phase("first_tick", 0, 2);
        step(1);
        check("tick_pulse_end", 32'(bus.tick), 0);

        // 2: plain rotation, exact phase lengths
        step(6);
        chk_phase("ng_last", 0, 1);
        step(1);
        chk_phase("ny_start", 1, 2);
        for (int k = 0; k < 7; k++) begin
            int dur;
            int prev;
            dur  = (k % 2 == 0) ? 8 : 12;
            prev = (k == 0) ? 1 : exp_q[k-1];
            step(dur - 1);
            chk_phase($sformatf("rot%0d_last", k), prev, 1);
            step(1);
            chk_phase($sformatf("rot%0d_new", k), exp_q[k], (exp_q[k] % 2 == 1) ? 2 : 3);
        end

        // 3: only S waiting -> N yellow jumps to S green, then S re-served
        step(12);
        chk_phase("n_yellow", 1, 2);
        bus.car_present = 4'b1000;
        step(8);
        chk_phase("skip_to_s", 6, 3);
        step(20);
        chk_phase("s_reserve", 6, 3);

        // 4: only N waiting; demand changes during green are ignored
        bus.car_present = 4'b0100;
        step(12);
        bus.car_present = 4'b0001;
        step(8);
        chk_phase("s_to_n", 0, 3);
        step(20);
        chk_phase("n_reserve", 0, 3);

        // 5: hold during W green, sec_left=2
        bus.car_present = 4'b0000;
        step(20);
        chk_phase("w_green", 2, 3);
        step(4);
        chk_phase("w_sec2", 2, 2);
        step(1);
        bus.hold = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(1);
            check($sformatf("hold%0d.tick", k), 32'(bus.tick), 0);
        end
        chk_phase("hold_end", 2, 2);
        bus.hold = 1'b0;
        step(2);
        check("resume.notick", 32'(bus.tick), 0);
        step(1);
        check("resume.tick", 32'(bus.tick), 1);
        chk_phase("resume", 2, 1);
        // hold on the tick edge wins
        step(3);
        bus.hold = 1'b1;
        step(1);
        check("hold_edge.tick", 32'(bus.tick), 0);
        chk_phase("hold_edge", 2, 1);
        bus.hold = 1'b0;
        step(1);
        check("after_hold_edge.tick", 32'(bus.tick), 1);
        chk_phase("after_hold_edge", 3, 2);

        // 6: reset mid-phase at Q=101, sec_left=1, one edge before expiry
        step(8);
        chk_phase("e_green", 4, 3);
        step(16);
        chk_phase("e_yellow_last", 5, 1);
        step(3);
        reset_n = 1'b0;
        step(1);
        chk_phase("mid_rst", 0, 3);
        check("mid_rst.tick", 32'(bus.tick), 0);
        reset_n = 1'b1;
        step(3);
        check("post_rst.notick", 32'(bus.tick), 0);
        chk_phase("post_rst", 0, 3);
        step(1);
        check("post_rst.tick", 32'(bus.tick), 1);
        chk_phase("post_rst_tick", 0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
